// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 fetch stage with prefetch FIFO and IF/ID register
// Optional FETCH_STATS_EN adds bubble and redirect counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pc_stall,
    input  logic        i_if_id_stall,
    input  logic        i_if_id_flush,
    input  logic [1:0]  i_pc_src_e,
    input  logic        i_jmp_e,
    input  logic        i_mret_e,
    input  logic [31:0] i_target_e,
    input  logic [31:0] i_mret_pc_e,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic [31:0] o_instr_d,
    output logic [31:0] o_pc_d,
    output logic [31:0] o_pc_plus4_d,
    output logic        o_valid_d
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] o_bubble_cnt,
    output logic [31:0] o_redirect_cnt
`endif
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_S = (CW+1)'(BUF_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;     // PC of the next response that will be kept
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_instr [BUF_DEPTH];
    logic [31:0]   fifo_pc    [BUF_DEPTH];

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          credit_ok;
    logic          issue;
    logic          rsp_live;
    logic          rsp_keep;
    logic          id_load;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          fifo_push;
    logic [CW-1:0] inflight_less;
    logic [CW-1:0] drop_next;

    assign redirect      = i_mret_e | i_jmp_e | (i_pc_src_e == 2'b01);
    assign redirect_pc   = (i_mret_e ? i_mret_pc_e : i_target_e) & ~32'h3;
    assign credit_ok     = ({1'b0, inflight} + {1'b0, fifo_cnt}) < DEPTH_S;
    assign o_imem_req_valid = (state != S_BOOT) && !redirect && !i_pc_stall && credit_ok;
    assign o_imem_addr   = fetch_pc;
    assign issue         = o_imem_req_valid && i_imem_req_ready;
    // A response with nothing outstanding belongs to a request from before reset.
    assign rsp_live      = i_imem_rsp_valid && (inflight != '0);
    assign rsp_keep      = rsp_live && (drop == '0) && !redirect;
    assign fifo_empty    = (fifo_cnt == '0);
    assign id_load       = !redirect && !i_if_id_flush && !i_if_id_stall;
    assign fifo_pop      = id_load && !fifo_empty;
    assign fifo_push     = rsp_keep && !(id_load && fifo_empty);
    assign inflight_less = inflight - CW'(rsp_live);

    always_comb begin
        drop_next = drop;
        if (redirect)
            drop_next = inflight_less;
        else if (rsp_live && (drop != '0))
            drop_next = drop - CW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_BOOT;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= inflight_less + CW'(issue);
            drop     <= drop_next;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                fifo_cnt <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                state    <= (drop_next != '0) ? S_DRAIN : S_RUN;
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp_keep)
                    rsp_pc <= rsp_pc + 32'd4;
                if (fifo_push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (fifo_pop)
                    rd_ptr <= rd_ptr + PW'(1);
                fifo_cnt <= fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
                if (state == S_BOOT)
                    state <= S_RUN;
                else if (state == S_DRAIN && drop_next == '0)
                    state <= S_RUN;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (fifo_push) begin
            fifo_instr[wr_ptr] <= i_imem_rsp_data;
            fifo_pc[wr_ptr]    <= rsp_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_instr_d    <= NOP_INSTR;
            o_pc_d       <= 32'd0;
            o_pc_plus4_d <= 32'd4;
            o_valid_d    <= 1'b0;
        end else if (redirect || i_if_id_flush) begin
            o_instr_d <= NOP_INSTR;
            o_valid_d <= 1'b0;
        end else if (!i_if_id_stall) begin
            if (!fifo_empty) begin
                o_instr_d    <= fifo_instr[rd_ptr];
                o_pc_d       <= fifo_pc[rd_ptr];
                o_pc_plus4_d <= fifo_pc[rd_ptr] + 32'd4;
                o_valid_d    <= 1'b1;
            end else if (rsp_keep) begin
                o_instr_d    <= i_imem_rsp_data;
                o_pc_d       <= rsp_pc;
                o_pc_plus4_d <= rsp_pc + 32'd4;
                o_valid_d    <= 1'b1;
            end else begin
                o_instr_d <= NOP_INSTR;
                o_valid_d <= 1'b0;
            end
        end
    end

    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(fifo_push && !fifo_pop && fifo_cnt == DEPTH_C));

`ifdef FETCH_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bubble_cnt   <= '0;
            o_redirect_cnt <= '0;
        end else begin
            if (state != S_BOOT && !o_valid_d && o_bubble_cnt != '1)
                o_bubble_cnt <= o_bubble_cnt + 32'd1;
            if (redirect && o_redirect_cnt != '1)
                o_redirect_cnt <= o_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule
